conv_mac_19: RTL and testbench

//   Dot-product stage for conv layer 19, directly downstream of the layer-19 weight streamer.
//   - Pops one signed coefficient from the weight FIFO and one signed activation from the data FIFO per cycle.
//   - Accumulates KERN_SIZE products.
//   - Requantizes: rounding arithmetic shift, optional ReLU, signed saturation.
//   - Pushes one result per kernel window into the output FIFO.
//   - All three stream ports use the HLS ap_fifo protocol.

---
 rtl/conv_mac_19.sv | 114 +++++++++++
 tb/tb_conv_mac_19.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_19.sv
// Layer-19 convolution MAC: pops weight/activation pairs over ap_fifo ports, accumulates
// KERN_SIZE products, requantizes (round, shift, optional ReLU, saturate), pushes one result.
`timescale 1ns/1ps
module conv_mac_19 #(
    parameter int COEFF_W   = 16,
    parameter int DATA_W    = 16,
    parameter int KERN_SIZE = 27,
    parameter int ACC_W     = 40,
    parameter int SHIFT     = 8,
    parameter int RELU      = 0
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic signed [COEFF_W-1:0] weight_V_dout,
    input  logic                      weight_V_empty_n,
    output logic                      weight_V_read,
    input  logic signed [DATA_W-1:0]  data_V_dout,
    input  logic                      data_V_empty_n,
    output logic                      data_V_read,
    output logic signed [DATA_W-1:0]  output_V_din,
    input  logic                      output_V_full_n,
    output logic                      output_V_write
);

    typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

    localparam int CNT_W = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERN_SIZE - 1);
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

    // One guard bit above the accumulator keeps the rounding add from overflowing.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W:0] xe;
        xe = {x[ACC_W-1], x};
        return (xe + RND) >>> SHIFT;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W:0] y);
        if (y > SAT_MAX) return DATA_W'(SAT_MAX);
        if (y < SAT_MIN) return DATA_W'(SAT_MIN);
        return DATA_W'(y);
    endfunction

    function automatic logic signed [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W:0] y;
        y = round_shift(x);
        if (RELU != 0 && y < 0) y = '0;
        return saturate(y);
    endfunction

    state_t                      state_q, state_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [DATA_W-1:0]    res_q, res_d;
    logic signed [COEFF_W+DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]     sum;
    logic                        fire;

    assign prod = weight_V_dout * data_V_dout;
    assign sum  = acc_q + ACC_W'(prod);
    // Reset gates the pop strobes so nothing leaves the FIFOs while ap_rst_n is low.
    assign fire = ap_rst_n & weight_V_empty_n & data_V_empty_n & (state_q == ST_ACC);
    assign output_V_din = res_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        res_d          = res_q;
        weight_V_read  = 1'b0;
        data_V_read    = 1'b0;
        output_V_write = 1'b0;
        case (state_q)
            ST_ACC: begin
                if (fire) begin
                    weight_V_read = 1'b1;
                    data_V_read   = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        res_d   = requant(sum);
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ST_OUT;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OUT: begin
                output_V_write = output_V_full_n;
                if (output_V_full_n) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_conv_mac_19.sv
// Bench for conv_mac_19: three instances (SHIFT=8; SHIFT=0; SHIFT=0 with ReLU) share one stimulus
// and are checked against an arithmetic dot-product model and a table of hand-computed windows.
`timescale 1ns/1ps
module tb_conv_mac_19;
    localparam int K = 27;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [15:0] w_dout, d_dout;
    logic w_en, d_en, full_n;
    logic rd_w8, rd_d8, wr8, rd_w0, rd_d0, wr0, rd_wr, rd_dr, wrr;
    logic signed [15:0] din8, din0, dinr;

    always #5 clk = ~clk;

    conv_mac_19 #(.SHIFT(8), .RELU(0)) dut8 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(rd_w8),
        .data_V_dout(d_dout), .data_V_empty_n(d_en), .data_V_read(rd_d8),
        .output_V_din(din8), .output_V_full_n(full_n), .output_V_write(wr8));
    conv_mac_19 #(.SHIFT(0), .RELU(0)) dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(rd_w0),
        .data_V_dout(d_dout), .data_V_empty_n(d_en), .data_V_read(rd_d0),
        .output_V_din(din0), .output_V_full_n(full_n), .output_V_write(wr0));
    conv_mac_19 #(.SHIFT(0), .RELU(1)) dutr (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(rd_wr),
        .data_V_dout(d_dout), .data_V_empty_n(d_en), .data_V_read(rd_dr),
        .output_V_din(dinr), .output_V_full_n(full_n), .output_V_write(wrr));

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    typedef struct { longint e8; longint e0; longint er; } exp_t;
    exp_t exp_q[$];

    typedef struct {
        string name;
        int w0; int d0; int w; int d;
        int e8; int e0; int er;
    } vec_t;
    vec_t vt[9];

    // Requantization from first principles: floor((sum + half) / 2^sh), ReLU, clamp.
    function automatic longint model(input longint s, input int sh, input bit relu);
        longint y, p, n;
        if (sh == 0) y = s;
        else begin
            p = longint'(1) << sh;
            n = s + p / 2;
            y = n / p;
            if (n < 0 && (n % p) != 0) y = y - 1;
        end
        if (relu && y < 0) y = 0;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: records every pop, forms expected results per window, checks every push.
    longint win_sum = 0;
    int win_n = 0;
    longint first_cyc = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            win_sum = 0;
            win_n = 0;
        end else begin
            checks++;
            if (rd_w8 !== rd_d8 || rd_w0 !== rd_w8 || rd_d0 !== rd_w8 || rd_wr !== rd_w8 || rd_dr !== rd_w8) begin
                errors++;
                $display("FAIL strobe_eq t=%0t w8=%b d8=%b w0=%b d0=%b wr=%b dr=%b required all equal",
                         $time, rd_w8, rd_d8, rd_w0, rd_d0, rd_wr, rd_dr);
            end
            checks++;
            if ((rd_w8 || rd_d8) && !(w_en && d_en)) begin
                errors++;
                $display("FAIL pop_while_empty t=%0t read=%b/%b empty_n=%b/%b required no pop",
                         $time, rd_w8, rd_d8, w_en, d_en);
            end
            if (rd_w8) begin
                if (win_n == 0) first_cyc = cyc;
                win_sum += longint'(w_dout) * longint'(d_dout);
                win_n++;
                if (win_n == K) begin
                    exp_q.push_back('{model(win_sum, 8, 1'b0), model(win_sum, 0, 1'b0), model(win_sum, 0, 1'b1)});
                    win_n = 0;
                    win_sum = 0;
                end
            end
            if (wr8 || wr0 || wrr) begin
                checks++;
                if (exp_q.size() == 0 || wr0 !== wr8 || wrr !== wr8) begin
                    errors++;
                    $display("FAIL unexpected_write t=%0t wr=%b%b%b pending=%0d", $time, wr8, wr0, wrr, exp_q.size());
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (longint'(din8) != e.e8 || longint'(din0) != e.e0 || longint'(dinr) != e.er) begin
                        errors++;
                        $display("FAIL sb_result t=%0t got %0d/%0d/%0d required %0d/%0d/%0d",
                                 $time, din8, din0, dinr, e.e8, e.e0, e.er);
                    end
                end
            end
        end
    end

    task automatic send_pair(input int w, input int d, input int wbub);
        bit got;
        got = 1'b0;
        if (wbub > 0) begin
            w_en = 1'b0;
            d_en = 1'b1;
            d_dout = 16'(d);
            w_dout = 16'($urandom);
            repeat (wbub) begin @(posedge clk); #1; end
        end
        w_dout = 16'(w);
        d_dout = 16'(d);
        w_en = 1'b1;
        d_en = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rd_w8) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL pop_timeout t=%0t no pop within 200 cycles", $time);
        end
        @(posedge clk); #1;
        w_en = 1'b0;
        d_en = 1'b0;
    endtask

    task automatic wait_write(output logic signed [15:0] o8, output logic signed [15:0] o0,
                              output logic signed [15:0] orl, output longint c);
        bit got;
        got = 1'b0;
        o8 = '0; o0 = '0; orl = '0; c = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (wr8) begin
                got = 1'b1; o8 = din8; o0 = din0; orl = dinr; c = cyc;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL write_timeout t=%0t no write within 300 cycles", $time);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (rd_w8 !== 1'b0 || rd_d8 !== 1'b0 || wr8 !== 1'b0 || din8 !== 16'sd0 || din0 !== 16'sd0 || wrr !== 1'b0) begin
            errors++;
            $display("FAIL %s rd=%b%b wr=%b din=%0d/%0d required all 0", nm, rd_w8, rd_d8, wr8, din8, din0);
        end
    endtask

    logic signed [15:0] o8, o0, orl;
    longint wc;

    initial begin
        vt[0] = '{"t1_ones",     256,    1,   256,     1,     27,  6912,   6912};
        vt[1] = '{"t4_pos_sat",  32767,  32767, 32767, 32767, 32767, 32767, 32767};
        vt[2] = '{"t5_neg_sat", -32768,  32767, -32768, 32767, -32768, -32768, 0};
        vt[3] = '{"t6_half_up",  384,    1,   0,       0,      2,   384,    384};
        vt[4] = '{"t7_neg_half", -384,   1,   0,       0,     -1,  -384,    0};
        vt[5] = '{"neg_one",     -1,     1,   0,       0,      0,    -1,    0};
        vt[6] = '{"exact_half",  128,    1,   0,       0,      1,   128,    128};
        vt[7] = '{"below_half",  127,    1,   0,       0,      0,   127,    127};
        vt[8] = '{"mixed_sign",  100,   -3,   2,       5,      0,   -40,    0};

        rst_n = 1'b0;
        w_en = 1'b1; d_en = 1'b1; full_n = 1'b1;
        w_dout = 16'sd5; d_dout = 16'sd7;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset_state");
        end
        @(posedge clk); #1;
        w_en = 1'b0; d_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            send_pair(vt[v].w0, vt[v].d0, 0);
            for (int i = 1; i < K; i++) send_pair(vt[v].w, vt[v].d, 0);
            wait_write(o8, o0, orl, wc);
            checks++;
            if (int'(o8) != vt[v].e8 || int'(o0) != vt[v].e0 || int'(orl) != vt[v].er) begin
                errors++;
                $display("FAIL %s got %0d/%0d/%0d required %0d/%0d/%0d",
                         vt[v].name, o8, o0, orl, vt[v].e8, vt[v].e0, vt[v].er);
            end
            checks++;
            if (wc - first_cyc + 1 != 28) begin
                errors++;
                $display("FAIL %s_latency got cycle %0d required 28", vt[v].name, wc - first_cyc + 1);
            end
        end

        // Output stall with fresh input pairs on offer: nothing may move.
        full_n = 1'b0;
        for (int i = 0; i < K; i++) send_pair(256, 1, 0);
        w_en = 1'b1; d_en = 1'b1; w_dout = 16'sd3; d_dout = 16'sd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (wr8 !== 1'b0 || rd_w8 !== 1'b0 || rd_d8 !== 1'b0 || din8 !== 16'sd27 || din0 !== 16'sd6912) begin
                errors++;
                $display("FAIL t3_stall cyc%0d wr=%b rd=%b%b din=%0d/%0d required 0,00,27/6912",
                         i, wr8, rd_w8, rd_d8, din8, din0);
            end
        end
        @(posedge clk); #1;
        full_n = 1'b1; w_en = 1'b0; d_en = 1'b0;
        @(negedge clk);
        checks++;
        if (wr8 !== 1'b1 || din8 !== 16'sd27) begin
            errors++;
            $display("FAIL t3_release wr=%b din=%0d required 1,27", wr8, din8);
        end
        @(posedge clk); #1;

        // Randomized windows with weight-FIFO bubbles while activations stay available.
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < K; i++)
                send_pair(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
            wait_write(o8, o0, orl, wc);
        end

        // Reset mid-window: the partial sum must not leak into the next window.
        for (int i = 0; i < 10; i++) send_pair(1000, 1000, 0);
        rst_n = 1'b0;
        w_en = 1'b1; d_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("t8_in_reset");
        end
        @(posedge clk); #1;
        rst_n = 1'b1; w_en = 1'b0; d_en = 1'b0;
        send_pair(-384, 1, 0);
        for (int i = 1; i < K; i++) send_pair(0, 0, 0);
        wait_write(o8, o0, orl, wc);
        checks++;
        if (o8 != -16'sd1 || o0 != -16'sd384 || orl != 16'sd0) begin
            errors++;
            $display("FAIL t8_fresh got %0d/%0d/%0d required -1/-384/0", o8, o0, orl);
        end

        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results got %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
